// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the pending-write scoreboard beside the ID stage.
package hazard_scoreboard_pkg;
  localparam int DEF_NREG   = 16;
  localparam int DEF_CNT_W  = 2;
  localparam int DEF_PC_REG = 15;
  localparam int REG_W      = 4;
  localparam int PERF_W     = 32;
endpackage

// File: rtl/hazard_scoreboard_sb_counter.sv
// One per-register pending-write counter: up on issue, down on retire, sticky underflow.
module sb_counter
  import hazard_scoreboard_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             underflow_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             uf_q, uf_d;

  // Issue and retire to the same register cancel; a retire at zero is a bookkeeping error.
  always_comb begin
    cnt_d = cnt_q;
    uf_d  = uf_q;
    if (inc_i && !dec_i) begin
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) uf_d  = 1'b1;
      else             cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      uf_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      uf_q  <= uf_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign underflow_o = uf_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard controller: per-register pending-write counters between ID issue and WB retire.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG   = DEF_NREG,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int PC_REG = DEF_PC_REG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_wb_en,
  input  logic [REG_W-1:0]  id_dest,
  input  logic [REG_W-1:0]  id_rn,
  input  logic [REG_W-1:0]  id_rdm,
  input  logic              id_two_src,
  input  logic              id_cond_pass,
  input  logic              freeze,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [REG_W-1:0]  wb_dest,
  output logic              hazard,
  output logic [NREG-1:0]   busy_mask,
  output logic              err_underflow,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam logic [REG_W-1:0] PC_IDX = REG_W'(PC_REG);

  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [NREG-1:0]            inc, dec, busy, uf;
  logic                       rn_busy, rdm_busy, sat, issue, retire;
  logic [PERF_W-1:0]          stall_q, stall_d;

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk         (clk),
      .rst         (rst),
      .inc_i       (inc[g]),
      .dec_i       (dec[g]),
      .cnt_o       (cnt[g]),
      .underflow_o (uf[g])
    );
    assign busy[g] = |cnt[g];
  end

  // Counters are pre-edge state, so a register retiring this cycle still stalls once.
  assign rn_busy  = busy[id_rn]  && (id_rn  != PC_IDX);
  assign rdm_busy = busy[id_rdm] && (id_rdm != PC_IDX);
  assign sat      = id_wb_en && (cnt[id_dest] == '1);
  assign hazard   = id_valid && (rn_busy || (id_two_src && rdm_busy) || sat);

  assign issue  = id_valid && id_wb_en && id_cond_pass && !hazard && !freeze && !flush
                  && (id_dest != PC_IDX);
  assign retire = wb_en && (wb_dest != PC_IDX);

  assign inc = issue  ? (NREG'(1) << id_dest) : '0;
  assign dec = retire ? (NREG'(1) << wb_dest) : '0;

  always_comb begin
    stall_d = stall_q;
    if (hazard && !freeze && (stall_q != '1)) stall_d = stall_q + PERF_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign busy_mask     = busy;
  assign err_underflow = |uf;
  assign stall_cycles  = stall_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed plan scenarios plus randomized traffic against an array-of-counts reference model.
module tb_hazard_scoreboard;
  logic        clk = 1'b0, rst = 1'b0;
  logic        id_valid, id_wb_en, id_two_src, id_cond_pass, freeze, flush, wb_en;
  logic [3:0]  id_dest, id_rn, id_rdm, wb_dest;
  logic        hazard, err_underflow;
  logic [15:0] busy_mask;
  logic [31:0] stall_cycles;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_wb_en(id_wb_en), .id_dest(id_dest),
    .id_rn(id_rn), .id_rdm(id_rdm), .id_two_src(id_two_src), .id_cond_pass(id_cond_pass),
    .freeze(freeze), .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest), .hazard(hazard),
    .busy_mask(busy_mask), .err_underflow(err_underflow), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int      n_chk = 0, n_err = 0;
  int      m_cnt[16];
  bit      m_err;
  longint  m_stall;
  logic    obs_haz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_mask();
    logic [15:0] m = '0;
    for (int i = 0; i < 16; i++) m[i] = (m_cnt[i] != 0);
    return m;
  endfunction

  function automatic bit m_hazard();
    bit rn_b  = (m_cnt[id_rn]  > 0) && (id_rn  != 15);
    bit rdm_b = (m_cnt[id_rdm] > 0) && (id_rdm != 15);
    bit sat_b = id_wb_en && (m_cnt[id_dest] == 3);
    return id_valid && (rn_b || (id_two_src && rdm_b) || sat_b);
  endfunction

  // Called at a negedge: apply inputs, check, advance model over the next posedge.
  task automatic cyc(input logic v, wbe, input logic [3:0] dst, rn, rdm,
                     input logic two, cp, frz, fl, wen, input logic [3:0] wdst);
    bit h, iss, ret;
    id_valid = v; id_wb_en = wbe; id_dest = dst; id_rn = rn; id_rdm = rdm;
    id_two_src = two; id_cond_pass = cp; freeze = frz; flush = fl;
    wb_en = wen; wb_dest = wdst;
    #1;
    h = m_hazard();
    obs_haz = hazard;
    chk("hazard", {31'b0, hazard}, {31'b0, h});
    chk("busy_mask", {16'b0, busy_mask}, {16'b0, m_mask()});
    chk("err_underflow", {31'b0, err_underflow}, {31'b0, m_err});
    chk("stall_cycles", stall_cycles, m_stall[31:0]);
    iss = v && wbe && cp && !h && !frz && !fl && dst != 15;
    ret = wen && wdst != 15;
    if (!(iss && ret && dst == wdst)) begin
      if (iss) m_cnt[dst]++;
      if (ret) begin
        if (m_cnt[wdst] == 0) m_err = 1;
        else m_cnt[wdst]--;
      end
    end
    if (h && !frz && m_stall < 64'hFFFF_FFFF) m_stall++;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_err = 0; m_stall = 0;
    chk("rst_busy", {16'b0, busy_mask}, 32'h0);
    chk("rst_err", {31'b0, err_underflow}, 32'h0);
    chk("rst_stall", stall_cycles, 32'h0);
    chk("rst_hazard", {31'b0, hazard}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] mk;
    int          s0, pick;
    id_valid = 0; id_wb_en = 0; id_dest = 0; id_rn = 0; id_rdm = 0; id_two_src = 0;
    id_cond_pass = 0; freeze = 0; flush = 0; wb_en = 0; wb_dest = 0;
    @(negedge clk);
    do_reset();

    // 1: issue R1, dependent read stalls, retire releases a cycle later
    cyc(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("t1_busy", {16'b0, busy_mask}, 32'h2);
    cyc(1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1);
    chk("t1_haz_same_wb", {31'b0, obs_haz}, 32'h1);
    cyc(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    chk("t1_haz_released", {31'b0, obs_haz}, 32'h0);
    chk("t1_busy_clear", {16'b0, busy_mask}, 32'h0);

    // 2: second-source hazard only when two_src
    cyc(1, 1, 3, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 4, 3, 1, 1, 0, 0, 0, 0);
    chk("t2_two_src", {31'b0, obs_haz}, 32'h1);
    cyc(1, 0, 0, 4, 3, 0, 1, 0, 0, 0, 0);
    chk("t2_one_src", {31'b0, obs_haz}, 32'h0);

    // 3: same-register issue/retire cancels; different registers both apply
    cyc(1, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 1, 2, 0, 0, 0, 1, 0, 0, 1, 2);
    chk("t3_r2_held", {31'b0, busy_mask[2]}, 32'h1);
    cyc(1, 1, 5, 0, 0, 0, 1, 0, 0, 1, 2);
    chk("t3_r5_r2", {30'b0, busy_mask[5], busy_mask[2]}, 32'h2);

    // 4: saturate R7, fourth writer stalls structurally
    repeat (3) cyc(1, 1, 7, 0, 0, 0, 1, 0, 0, 0, 0);
    s0 = stall_cycles;
    cyc(1, 1, 7, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("t4_sat_haz", {31'b0, obs_haz}, 32'h1);
    cyc(1, 1, 7, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("t4_stall_inc", stall_cycles, s0 + 2);

    // 5: bogus retire sets sticky error; frozen issue changes nothing
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
    idle();
    chk("t5_err_held", {31'b0, err_underflow}, 32'h1);
    mk = busy_mask; s0 = stall_cycles;
    cyc(1, 1, 10, 0, 0, 0, 1, 1, 0, 0, 0);
    chk("t5_freeze_busy", {16'b0, busy_mask}, {16'b0, mk});
    chk("t5_freeze_stall", stall_cycles, s0);

    // 6: asynchronous reset mid-cycle with R4..R7 busy
    do_reset();
    for (int r = 4; r < 8; r++) cyc(1, 1, r[3:0], 0, 0, 0, 1, 0, 0, 0, 0);
    chk("t6_busy_f0", {16'b0, busy_mask}, 32'hF0);
    #2;
    do_reset();
    cyc(1, 1, 11, 0, 0, 0, 1, 0, 1, 0, 0);
    chk("t6_flush", {16'b0, busy_mask}, 32'h0);
    cyc(1, 1, 15, 15, 15, 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 15, 15, 1, 1, 0, 0, 0, 0);
    chk("t6_pc_no_haz", {31'b0, obs_haz}, 32'h0);

    // Randomized traffic; retires mostly target registers with work in flight
    do_reset();
    for (int k = 0; k < 600; k++) begin
      logic [3:0] wd;
      wd = 4'($urandom_range(15));
      if ($urandom_range(99) < 85) begin
        pick = -1;
        for (int t = 0; t < 16 && pick < 0; t++) begin
          int r = int'($urandom_range(15));
          if (m_cnt[r] > 0) pick = r;
        end
        if (pick >= 0) wd = 4'(pick);
      end
      cyc($urandom_range(7) != 0, $urandom_range(3) != 0, 4'($urandom_range(15)),
          4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)),
          $urandom_range(9) != 0, $urandom_range(9) == 0, $urandom_range(9) == 0,
          1'($urandom_range(1)), wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Scoreboard-based hazard controller for the ARM 5-stage pipeline. It tracks pending register writes between ID issue and WB retire, and drives the `hazard` input of the decode stage. When the decode stage holds a bubble, it zeroes its control outputs. The block sits beside the ID stage and observes the ID→EX issue and the WB write port. It replaces pairwise EX/MEM destination comparison with per-register pending-write counters.

Parameters:
NREG, 16, number of architectural registers tracked (index width 4).
CNT_W, 2, width of each per-register pending-write counter (max 2^CNT_W-1 in flight).
PC_REG, 15, register index that never creates a hazard (reads return PC).

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous reset, active-high
id_valid  in  1  ID holds a real (non-flushed) instruction
id_wb_en  in  1  decoded wb_en of the instruction in ID (before hazard muxing)
id_dest  in  4  destination register (instr[15:12])
id_rn  in  4  source 1 (hazardRn)
id_rdm  in  4  source 2 (hazardRdm; Rm or Rd for store)
id_two_src  in  1  second source is read (hazardTwoSrc)
id_cond_pass  in  1  condition check passed in ID
freeze  in  1  global pipeline stall (memory wait); no issue this cycle
flush  in  1  branch taken in EX; the ID instruction is discarded
wb_en  in  1  WB register-file write enable
wb_dest  in  4  WB destination
hazard  out  1  stall ID/IF, insert bubble into EX
busy_mask  out  16  bit i = counter[i] != 0
err_underflow  out  1  sticky: retire seen for a register with counter 0
stall_cycles  out  32  count of cycles with hazard=1 and freeze=0

Behaviour:
- Reset (async, rst=1): all counters 0; busy_mask=0; err_underflow=0; stall_cycles=0; hazard=0.
- hazard is combinational from the current counter state and ID inputs, with zero-cycle latency:
  - hazard = id_valid & ((rn_busy & id_rn!=PC_REG) | (id_two_src & rdm_busy & id_rdm!=PC_REG) | sat).
  - sat = id_wb_en & counter[id_dest]==max. This is a structural stall when the counter is saturated.
- issue = id_valid & id_wb_en & id_cond_pass & ~hazard & ~freeze & ~flush & (id_dest != PC_REG).
- retire = wb_en & (wb_dest != PC_REG).
- Per clock edge, on counter[i]:
  - issue only to i: +1.
  - retire only to i: -1.
  - issue and retire on the same i: unchanged.
  - issue and retire on different registers: both applied.
- Retire to a counter at 0: counter stays 0; err_underflow set to 1 and held until rst.
- Counters never wrap; the sat stall guarantees no overflow.
- freeze=1: no increments. Retires still apply, because WB writes are independent of freeze.
- flush=1: no increment for the ID instruction. Instructions already issued stay counted and retire normally. A flushed EX instruction has its WB enable gated by the pipeline, so the team's pipeline must not flush past EX.
- stall_cycles increments when hazard & ~freeze and saturates at 2^32-1.
- Same-cycle RAW on WB: hazard uses pre-edge counters. A register retiring this cycle still stalls for one cycle, because the register file writes on the negedge and releases next cycle.
- busy_mask is registered, reflecting the counters after the edge.

Decomposition:
- Shared package/header: NREG, PC_REG, CNT_W defaults, register-index width constant.
- One natural sub-module: sb_counter (one saturating up/down counter with an underflow flag), instantiated NREG times via generate.
- Top level holds the decode of id_dest/wb_dest into one-hot inc/dec vectors, hazard logic and the perf counter.

Test Plan:
1. After reset: ADD R1 issued (id_dest=1, id_wb_en=1) → busy_mask=0x0002 next cycle. Next instruction reads Rn=1 → hazard=1. Assert wb_en with wb_dest=1 → busy_mask=0x0000 and hazard=0 the following cycle.
2. Store with id_two_src=1, id_rdm=3 while counter[3]=1 → hazard=1. Same stimulus with id_two_src=0 and id_rn=4 idle → hazard=0.
3. Issue to R2 and retire R2 in the same cycle with counter[2]=1 → counter[2] stays 1. Issue R5 and retire R2 together → counters R5=1, R2=0.
4. Three issues to R7 (CNT_W=2) → counter=3. A fourth instruction writing R7 → hazard=1, no increment, stall_cycles +1 per cycle.
5. retire R9 with counter 0 → err_underflow=1 and held. freeze=1 with a valid issue → no counter change and stall_cycles unchanged.
6. Reset mid-operation with busy_mask=0x00F0 → all outputs 0 immediately, without waiting for a clock edge. flush=1 during a valid issue → counters unchanged. Rn=15 with R15 referenced → hazard=0.
